// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM state encoding, opcode constants, instruction width and the sign-extend helper.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC select: jr > jump > taken branch > pc_plus4.
// Jump-register support is compiled in only when FETCH_JR_EN is defined.
module npc_sel
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               brchne,
  input  logic               alu_zero,
  input  logic               jump,
  input  logic               jr,
  input  logic [ADDR_W-1:0]  jr_target,
  output logic [ADDR_W-1:0]  next_pc
);

  logic              taken_c;
  logic [ADDR_W-1:0] br_tgt_c;
  logic [ADDR_W-1:0] j_tgt_c;

  assign taken_c  = (branch & alu_zero) | (brchne & ~alu_zero);
  assign br_tgt_c = pc_plus4 + ADDR_W'(sext16(instr[15:0]) << 2);
  assign j_tgt_c  = ADDR_W'({pc_plus4[ADDR_W-1 -: 4], instr[25:0], 2'b00});

`ifdef FETCH_JR_EN
  logic [ADDR_W-1:0] jr_tgt_c;
  logic              unused_bits;
  assign jr_tgt_c    = {jr_target[ADDR_W-1:2], 2'b00};
  assign unused_bits = ^{instr[31:26], jr_target[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{instr[31:26], jr, jr_target};
`endif

  // Priority chain masks lower-priority controls entirely.
  always_comb begin
    next_pc = pc_plus4;
`ifdef FETCH_JR_EN
    if (jr) begin
      next_pc = jr_tgt_c;
    end else
`endif
    if (jump) begin
      next_pc = j_tgt_c;
    end else if (taken_c) begin
      next_pc = br_tgt_c;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the IDLE/FETCH/WAIT/VALID handshake with instruction memory and
// advances the PC on retire. Optional jump-register support via FETCH_JR_EN (see npc_sel).
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  input  logic               branch,
  input  logic               brchne,
  input  logic               alu_zero,
  input  logic               jump,
  input  logic               jr,
  input  logic [ADDR_W-1:0]  jr_target
);

  localparam logic [ADDR_W-1:0] RESET_PC4 = RESET_PC + ADDR_W'(4);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  next_pc_c;

  npc_sel #(.ADDR_W(ADDR_W)) u_npc_sel (
    .pc_plus4  (pc_plus4_q),
    .instr     (instr_q),
    .branch    (branch),
    .brchne    (brchne),
    .alu_zero  (alu_zero),
    .jump      (jump),
    .jr        (jr),
    .jr_target (jr_target),
    .next_pc   (next_pc_c)
  );

  // Next-state and registered-output decode; rvalid is only honoured while waiting.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d    = next_pc_c;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    pc_plus4_d = pc_d + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC4;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetch/retire traffic
// checked every cycle against a behavioural next-PC model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch, brchne, alu_zero, jump, jr;
  logic [31:0] jr_target;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .brchne      (brchne),
    .alu_zero    (alu_zero),
    .jump        (jump),
    .jr          (jr),
    .jr_target   (jr_target)
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic        exp_req, exp_valid, exp_rst;
  logic [31:0] exp_pc, exp_instr;
  logic [31:0] m_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, want, $time);
    end
  endtask

  // Next PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic br, input logic bne, input logic z,
                                             input logic jmp, input logic jrr,
                                             input logic [31:0] jt);
    logic [31:0] p4;
    int          imm;
    p4 = cur + 32'd4;
`ifdef FETCH_JR_EN
    if (jrr) return jt & 32'hFFFF_FFFC;
`endif
    if (jmp) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if ((br && z) || (bne && !z)) begin
      imm = int'(word & 32'h0000_FFFF);
      if (imm >= 32768) imm = imm - 65536;
      return p4 + 32'(imm * 4);
    end
    return p4;
  endfunction

  // Per-cycle compare against the expectations the driver publishes.
  always @(negedge clk) begin
    if (chk_en) begin
      check32("imem_req", 32'(imem_req), 32'(exp_req));
      check32("instr_valid", 32'(instr_valid), 32'(exp_valid));
      check32("pc", pc, exp_pc);
      check32("pc_plus4", pc_plus4, exp_pc + 32'd4);
      if (exp_req) check32("imem_addr", imem_addr, exp_pc);
      if (exp_valid || exp_rst) check32("instr", instr, exp_instr);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic br, input logic bne, input logic z, input logic jmp,
                          input logic jrr, input logic [31:0] jt);
    branch = br; brchne = bne; alu_zero = z; jump = jmp; jr = jrr; jr_target = jt;
  endtask

  // One fetch: request, d wait cycles, data, h stall cycles, retire with the given controls.
  task automatic txn(input logic [31:0] word, input logic br, input logic bne, input logic z,
                     input logic jmp, input logic jrr, input logic [31:0] jt,
                     input int d, input int h);
    next_cyc();
    exp_req = 1'b1; exp_valid = 1'b0; exp_rst = 1'b0; exp_pc = m_pc;
    instr_ready = 1'b0;
    imem_rvalid = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    for (int i = 0; i < d; i++) begin
      next_cyc();
      exp_req = 1'b0;
      imem_rvalid = 1'b0;
      instr_ready = 1'($urandom_range(0, 1));
    end
    next_cyc();
    exp_req = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = word; instr_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < h; i++) begin
      next_cyc();
      exp_valid = 1'b1; exp_instr = word;
      imem_rvalid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      instr_ready = 1'b0;
      set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end
    next_cyc();
    exp_valid = 1'b1; exp_instr = word;
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    set_ctrl(br, bne, z, jmp, jrr, jt);
    m_pc = model_next(m_pc, word, br, bne, z, jmp, jrr, jt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] jr_exp;
    rst_n = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    m_pc = RESET_PC;
    repeat (2) next_cyc();
    exp_req = 1'b0; exp_valid = 1'b0; exp_rst = 1'b1; exp_instr = '0; exp_pc = RESET_PC;
    chk_en = 1'b1;
    next_cyc();
    rst_n = 1'b1;

    // Reset release, first fetch, sequential retire.
    txn(32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1);
    check32("seq_pin", m_pc, 32'h0040_0004);
    txn(32'h1000_0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1, 0);
    check32("beq_fwd_pin", m_pc, 32'h0040_0010);
    txn(32'h1000_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    check32("beq_taken_pin", m_pc, 32'h0040_0004);
    txn(32'h1000_0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2, 1);
    txn(32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    check32("beq_not_taken_pin", m_pc, 32'h0040_0014);
    txn(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    check32("beq_back_pin", m_pc, 32'h0040_0010);
    txn(32'h1400_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3, 2);
    check32("bne_taken_pin", m_pc, 32'h0040_0004);
    txn(32'h1000_0006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    check32("to_0x20_pin", m_pc, 32'h0040_0020);

    // Jump with don't-care branch controls, then wrap around the address space.
    txn(32'h0810_0000, 1'bx, 1'bx, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0);
    check32("jump_pin", m_pc, 32'h0040_0000);
    txn(32'h0800_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    check32("jump_zero_pin", m_pc, 32'h0000_0000);
    txn(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
    check32("branch_wrap_pin", m_pc, 32'hFFFF_FFFC);
    txn(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 5);
    check32("pc_wrap_pin", m_pc, 32'h0000_0000);

    // Jump-register priority over jump.
`ifdef FETCH_JR_EN
    jr_exp = 32'h0040_0100;
`else
    jr_exp = 32'h0040_0000;
`endif
    txn(32'h0810_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0103, 0, 0);
    check32("jr_pin", m_pc, jr_exp);

    // Reset while waiting for read data; the late rvalid must be dropped.
    next_cyc();
    exp_req = 1'b1; exp_valid = 1'b0; exp_pc = m_pc;
    instr_ready = 1'b0; imem_rvalid = 1'b0;
    next_cyc();
    exp_req = 1'b0;
    rst_n = 1'b0;
    m_pc = RESET_PC;
    exp_rst = 1'b1; exp_instr = '0; exp_pc = RESET_PC; exp_valid = 1'b0;
    next_cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    next_cyc();
    rst_n = 1'b1;
    txn(32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
    check32("post_reset_pin", m_pc, 32'h0040_0004);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      txn($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    next_cyc();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
